// File: rtl/weapon_pkg.sv
// weapon_pkg
// Shared types and constants for the weapon attack sequencer.
//   weapon_state_t : attack FSM states
//   CLASS_*        : char_class encodings that enable attacks
//   GAME_PLAYING   : game_active value that enables attacks
//   *_DMG          : damage added per accepted hit
//   sat_add8       : 8-bit add that clamps at 255
package weapon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSwing,
        StFire,
        StCooldown
    } weapon_state_t;

    localparam logic [1:0] CLASS_MELEE  = 2'd1;
    localparam logic [1:0] CLASS_ARCHER = 2'd2;
    localparam logic [1:0] GAME_PLAYING = 2'd1;

    localparam logic [7:0] MELEE_DMG  = 8'd4;
    localparam logic [7:0] RANGED_DMG = 8'd1;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/weapon_attack_ctrl_if.sv
// weapon_attack_ctrl_if
// Bundles the frame/mouse/slot/hit inputs and the attack/damage outputs of the
// attack sequencer.
//   master : environment side (drives inputs, observes outputs)
//   slave  : weapon_attack_ctrl side
// Parameter PROJECTILE_COUNT sizes slot_busy and fire_slot.
interface weapon_attack_ctrl_if #(
    parameter int unsigned PROJECTILE_COUNT = 4
);
    localparam int unsigned SlotW = (PROJECTILE_COUNT > 1) ? $clog2(PROJECTILE_COUNT) : 1;

    logic                        frame_tick;
    logic [1:0]                  game_active;
    logic [1:0]                  char_class;
    logic                        mouse_clicked;
    logic [PROJECTILE_COUNT-1:0] slot_busy;
    logic                        melee_hit;
    logic                        projectile_hit;

    logic                        swing_start;
    logic                        swing_active;
    logic                        fire_req;
    logic [SlotW-1:0]            fire_slot;
    logic                        cooldown_active;
    logic                        dmg_valid;
    logic [7:0]                  dmg;

    modport master (
        output frame_tick, game_active, char_class, mouse_clicked, slot_busy,
               melee_hit, projectile_hit,
        input  swing_start, swing_active, fire_req, fire_slot, cooldown_active,
               dmg_valid, dmg
    );

    modport slave (
        input  frame_tick, game_active, char_class, mouse_clicked, slot_busy,
               melee_hit, projectile_hit,
        output swing_start, swing_active, fire_req, fire_slot, cooldown_active,
               dmg_valid, dmg
    );

endinterface

// File: rtl/free_slot_finder.sv
// free_slot_finder
// Combinational priority encoder: lowest index whose busy flag is clear.
//   slot_busy : per-slot in-flight flags
//   found     : at least one slot is free
//   index     : lowest free slot (0 when none is free)
module free_slot_finder #(
    parameter int unsigned SlotCount = 4,
    parameter int unsigned IdxW      = 2
) (
    input  logic [SlotCount-1:0] slot_busy,
    output logic                 found,
    output logic [IdxW-1:0]      index
);

    // Scan downwards so the lowest free slot is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = SlotCount - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                found = 1'b1;
                index = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/weapon_attack_ctrl.sv
// weapon_attack_ctrl
// Turns mouse click edges into rate-limited melee swings or projectile launches
// depending on char_class, and converts hit events into damage pulses.
//   clk, rst : system clock, asynchronous active-low reset
//   atk_if   : weapon_attack_ctrl_if.slave (frame_tick, game_active, char_class,
//              mouse_clicked, slot_busy, melee_hit, projectile_hit in;
//              swing_start, swing_active, fire_req, fire_slot, cooldown_active,
//              dmg_valid, dmg out). All outputs are registered.
// Build option: define WEAPON_CLICK_BUFFER_EN to remember one click made while
// busy and replay it on the first IDLE cycle.
module weapon_attack_ctrl
    import weapon_pkg::*;
#(
    parameter int unsigned PROJECTILE_COUNT = 4,
    parameter int unsigned SWING_FRAMES     = 10,
    parameter int unsigned MELEE_COOLDOWN   = 20,
    parameter int unsigned RANGED_COOLDOWN  = 12
) (
    input logic                 clk,
    input logic                 rst,
    weapon_attack_ctrl_if.slave atk_if
);

    localparam int unsigned SlotW   = (PROJECTILE_COUNT > 1) ? $clog2(PROJECTILE_COUNT) : 1;
    localparam int unsigned CntMaxA = (SWING_FRAMES > MELEE_COOLDOWN) ? SWING_FRAMES
                                                                      : MELEE_COOLDOWN;
    localparam int unsigned CntMax  = (CntMaxA > RANGED_COOLDOWN) ? CntMaxA : RANGED_COOLDOWN;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] SwingLoad  = CntW'(SWING_FRAMES);
    localparam logic [CntW-1:0] MeleeLoad  = CntW'(MELEE_COOLDOWN);
    localparam logic [CntW-1:0] RangedLoad = CntW'(RANGED_COOLDOWN);

    weapon_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mouse_q;
    logic [1:0]      class_q;
    logic            swing_hit_q, swing_hit_d;
`ifdef WEAPON_CLICK_BUFFER_EN
    logic            pend_q, pend_d;
`endif

    logic             swing_start_q, swing_start_d;
    logic             swing_active_q, swing_active_d;
    logic             fire_req_q, fire_req_d;
    logic [SlotW-1:0] fire_slot_q, fire_slot_d;
    logic             cooldown_active_q, cooldown_active_d;
    logic             dmg_valid_q, dmg_valid_d;
    logic [7:0]       dmg_q, dmg_d;

    logic             enabled, abort, click_edge, attack, cnt_last;
    logic             melee_take, ranged_take;
    logic             slot_found;
    logic [SlotW-1:0] slot_idx;

    free_slot_finder #(
        .SlotCount(PROJECTILE_COUNT),
        .IdxW     (SlotW)
    ) u_free_slot_finder (
        .slot_busy(atk_if.slot_busy),
        .found    (slot_found),
        .index    (slot_idx)
    );

    always_comb begin
        enabled    = (atk_if.game_active == GAME_PLAYING) &&
                     ((atk_if.char_class == CLASS_MELEE) || (atk_if.char_class == CLASS_ARCHER));
        // A class switch mid-attack is treated like losing enable.
        abort      = !enabled || (atk_if.char_class != class_q);
        click_edge = atk_if.mouse_clicked & ~mouse_q;
        cnt_last   = (cnt_q == CntW'(1));
`ifdef WEAPON_CLICK_BUFFER_EN
        attack     = click_edge | pend_q;
`else
        attack     = click_edge;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef WEAPON_CLICK_BUFFER_EN
        pend_d  = pend_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef WEAPON_CLICK_BUFFER_EN
                pend_d = 1'b0;
`endif
                if (attack) begin
                    if (atk_if.char_class == CLASS_MELEE) begin
                        state_d = StSwing;
                        cnt_d   = SwingLoad;
                    end else if (slot_found) begin
                        state_d = StFire;
                    end
                end
            end
            StSwing: begin
                if (atk_if.frame_tick) begin
                    if (cnt_last) begin
                        state_d = StCooldown;
                        cnt_d   = MeleeLoad;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StFire: begin
                state_d = StCooldown;
                cnt_d   = RangedLoad;
            end
            StCooldown: begin
                if (atk_if.frame_tick) begin
                    if (cnt_last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef WEAPON_CLICK_BUFFER_EN
        // Only one click is remembered; further edges while set are dropped.
        if ((state_q != StIdle) && click_edge) pend_d = 1'b1;
`endif
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
`ifdef WEAPON_CLICK_BUFFER_EN
            pend_d  = 1'b0;
`endif
        end
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        melee_take  = !abort && (state_q == StSwing) && atk_if.melee_hit && !swing_hit_q;
        ranged_take = !abort && atk_if.projectile_hit;
        swing_hit_d = (state_d == StSwing) && (swing_hit_q || melee_take);

        swing_start_d     = (state_q == StIdle) && (state_d == StSwing);
        swing_active_d    = (state_d == StSwing);
        fire_req_d        = (state_d == StFire);
        fire_slot_d       = fire_req_d ? slot_idx : '0;
        cooldown_active_d = (state_d == StCooldown);
        dmg_valid_d       = melee_take || ranged_take;
        dmg_d             = sat_add8(melee_take ? MELEE_DMG : 8'd0,
                                     ranged_take ? RANGED_DMG : 8'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            mouse_q           <= 1'b0;
            class_q           <= 2'd0;
            swing_hit_q       <= 1'b0;
            swing_start_q     <= 1'b0;
            swing_active_q    <= 1'b0;
            fire_req_q        <= 1'b0;
            fire_slot_q       <= '0;
            cooldown_active_q <= 1'b0;
            dmg_valid_q       <= 1'b0;
            dmg_q             <= 8'd0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            mouse_q           <= atk_if.mouse_clicked;
            class_q           <= atk_if.char_class;
            swing_hit_q       <= swing_hit_d;
            swing_start_q     <= swing_start_d;
            swing_active_q    <= swing_active_d;
            fire_req_q        <= fire_req_d;
            fire_slot_q       <= fire_slot_d;
            cooldown_active_q <= cooldown_active_d;
            dmg_valid_q       <= dmg_valid_d;
            dmg_q             <= dmg_valid_d ? dmg_d : 8'd0;
        end
    end

`ifdef WEAPON_CLICK_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    assign atk_if.swing_start     = swing_start_q;
    assign atk_if.swing_active    = swing_active_q;
    assign atk_if.fire_req        = fire_req_q;
    assign atk_if.fire_slot       = fire_slot_q;
    assign atk_if.cooldown_active = cooldown_active_q;
    assign atk_if.dmg_valid       = dmg_valid_q;
    assign atk_if.dmg             = dmg_q;

endmodule

// File: tb/tb_weapon_attack_ctrl.sv
// tb_weapon_attack_ctrl
// Self-checking bench for weapon_attack_ctrl (SWING_FRAMES=10, MELEE_COOLDOWN=20,
// RANGED_COOLDOWN=12, 4 slots). Expected pulse events are queued when stimulus
// is driven and popped when the DUT emits a pulse. Honours WEAPON_CLICK_BUFFER_EN.
module tb_weapon_attack_ctrl;
    import weapon_pkg::*;

    localparam int unsigned NSlots = 4;
    localparam int KSwing = 0;
    localparam int KFire  = 1;
    localparam int KDmg   = 2;

    typedef struct {
        int kind;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    weapon_attack_ctrl_if #(.PROJECTILE_COUNT(NSlots)) atk ();

    weapon_attack_ctrl #(
        .PROJECTILE_COUNT(NSlots),
        .SWING_FRAMES    (10),
        .MELEE_COOLDOWN  (20),
        .RANGED_COOLDOWN (12)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .atk_if(atk)
    );

    // Looks at the current sample first, then steps negedges; reports the first pulse.
    task automatic get_event(input int budget, output bit got, output int kind, output int data);
        got  = 1'b0;
        kind = -1;
        data = 0;
        for (int i = 0; i < budget; i++) begin
            if (atk.swing_start === 1'b1) begin
                got = 1'b1; kind = KSwing; data = 0; return;
            end
            if (atk.fire_req === 1'b1) begin
                got = 1'b1; kind = KFire; data = int'(atk.fire_slot); return;
            end
            if (atk.dmg_valid === 1'b1) begin
                got = 1'b1; kind = KDmg; data = int'(atk.dmg); return;
            end
            @(negedge clk);
        end
    endtask

    // Pulses frame_tick (with one idle cycle between frames) while the watched
    // output stays high; returns the number of ticks it took to drop.
    task automatic run_frames(input bit watch_swing, output int n);
        n = 0;
        while ((watch_swing ? atk.swing_active : atk.cooldown_active) === 1'b1 && n < 60) begin
            atk.frame_tick = 1'b1;
            @(negedge clk);
            atk.frame_tick = 1'b0;
            n++;
            if ((watch_swing ? atk.swing_active : atk.cooldown_active) === 1'b1) @(negedge clk);
        end
    endtask

    // Drop enable for one cycle to force IDLE.
    task automatic go_idle();
        atk.mouse_clicked = 1'b0;
        atk.game_active   = 2'd0;
        @(negedge clk);
        atk.game_active   = GAME_PLAYING;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_class(input logic [1:0] cls);
        atk.char_class    = cls;
        atk.mouse_clicked = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        atk.frame_tick     = 1'b0;
        atk.game_active    = GAME_PLAYING;
        atk.char_class     = CLASS_MELEE;
        atk.mouse_clicked  = 1'b0;
        atk.slot_busy      = '0;
        atk.melee_hit      = 1'b0;
        atk.projectile_hit = 1'b0;
        @(negedge clk);
        checks++;
        if ({atk.swing_start, atk.swing_active, atk.fire_req, atk.cooldown_active,
             atk.dmg_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got=%b required=00000", {atk.swing_start,
                     atk.swing_active, atk.fire_req, atk.cooldown_active, atk.dmg_valid});
        end
        checks++;
        if (atk.dmg !== 8'd0 || atk.fire_slot !== 2'd0) begin
            failures++;
            $display("FAIL reset_data: dmg=%0d fire_slot=%0d required 0/0", atk.dmg, atk.fire_slot);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (atk.swing_active !== 1'b0 || atk.cooldown_active !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: swing=%b cool=%b required 0/0",
                     atk.swing_active, atk.cooldown_active);
        end
    endtask

    task automatic test_melee();
        bit got; int kind; int data; int n; exp_t e;
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KSwing, 0});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind || data != e.data) begin
            failures++;
            $display("FAIL melee_start: got=%0b kind=%0d data=%0d required kind=%0d data=%0d",
                     got, kind, data, e.kind, e.data);
        end
        checks++;
        if (atk.swing_active !== 1'b1) begin
            failures++;
            $display("FAIL melee_active_rise: swing_active=%b required 1", atk.swing_active);
        end
        // Button stays held: still one swing only.
        @(negedge clk);
        checks++;
        if (atk.swing_start !== 1'b0) begin
            failures++;
            $display("FAIL melee_start_width: swing_start=%b required 0", atk.swing_start);
        end
        run_frames(1'b1, n);
        checks++;
        if (n != 10 || atk.cooldown_active !== 1'b1) begin
            failures++;
            $display("FAIL melee_swing_len: ticks=%0d cool=%b required 10/1", n, atk.cooldown_active);
        end
        atk.mouse_clicked = 1'b0;
        run_frames(1'b0, n);
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL melee_cool_len: ticks=%0d required 20", n);
        end
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KSwing, 0});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind) begin
            failures++;
            $display("FAIL melee_reclick: got=%0b kind=%0d required kind=%0d", got, kind, e.kind);
        end
        go_idle();
    endtask

    task automatic test_abort();
        bit got; int kind; int data; exp_t e;
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KSwing, 0});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind) begin
            failures++;
            $display("FAIL abort_start: got=%0b kind=%0d required kind=%0d", got, kind, e.kind);
        end
        @(negedge clk);
        atk.game_active    = 2'd0;
        atk.projectile_hit = 1'b1;
        @(negedge clk);
        atk.projectile_hit = 1'b0;
        checks++;
        if ({atk.swing_start, atk.swing_active, atk.fire_req, atk.cooldown_active,
             atk.dmg_valid} !== 5'b0 || atk.dmg !== 8'd0) begin
            failures++;
            $display("FAIL abort_outputs: flags=%b dmg=%0d required 00000/0", {atk.swing_start,
                     atk.swing_active, atk.fire_req, atk.cooldown_active, atk.dmg_valid}, atk.dmg);
        end
        atk.game_active = GAME_PLAYING;
        repeat (3) @(negedge clk);
        checks++;
        if (atk.swing_active !== 1'b0 || atk.cooldown_active !== 1'b0) begin
            failures++;
            $display("FAIL abort_stays_idle: swing=%b cool=%b required 0/0",
                     atk.swing_active, atk.cooldown_active);
        end
        atk.mouse_clicked = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_archer();
        bit got; int kind; int data; int n; exp_t e;
        set_class(CLASS_ARCHER);
        atk.slot_busy     = 4'b0101;
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KFire, 1});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind || data != e.data) begin
            failures++;
            $display("FAIL archer_fire: got=%0b kind=%0d slot=%0d required kind=%0d slot=%0d",
                     got, kind, data, e.kind, e.data);
        end
        @(negedge clk);
        checks++;
        if (atk.fire_req !== 1'b0 || atk.cooldown_active !== 1'b1) begin
            failures++;
            $display("FAIL archer_to_cool: fire_req=%b cool=%b required 0/1",
                     atk.fire_req, atk.cooldown_active);
        end
        atk.mouse_clicked = 1'b0;
        run_frames(1'b0, n);
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL archer_cool_len: ticks=%0d required 12", n);
        end
        atk.slot_busy     = 4'b1111;
        atk.mouse_clicked = 1'b1;
        @(negedge clk);
        get_event(5, got, kind, data);
        checks++;
        if (got || atk.cooldown_active !== 1'b0) begin
            failures++;
            $display("FAIL archer_full_drop: event=%0b kind=%0d cool=%b required no event, cool 0",
                     got, kind, atk.cooldown_active);
        end
        atk.slot_busy     = 4'b0111;
        atk.mouse_clicked = 1'b0;
        @(negedge clk);
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KFire, 3});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind || data != e.data) begin
            failures++;
            $display("FAIL archer_fire_hi: got=%0b kind=%0d slot=%0d required kind=%0d slot=%0d",
                     got, kind, data, e.kind, e.data);
        end
        go_idle();
        atk.slot_busy = '0;
    endtask

    task automatic test_damage();
        bit got; int kind; int data; exp_t e;
        set_class(CLASS_MELEE);
        atk.melee_hit = 1'b1;
        @(negedge clk);
        atk.melee_hit = 1'b0;
        get_event(3, got, kind, data);
        checks++;
        if (got) begin
            failures++;
            $display("FAIL dmg_melee_idle: event kind=%0d data=%0d required none", kind, data);
        end
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KSwing, 0});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind) begin
            failures++;
            $display("FAIL dmg_swing_start: got=%0b kind=%0d required kind=%0d", got, kind, e.kind);
        end
        atk.melee_hit      = 1'b1;
        atk.projectile_hit = 1'b1;
        exp_q.push_back('{KDmg, 5});
        @(negedge clk);
        atk.melee_hit      = 1'b0;
        atk.projectile_hit = 1'b0;
        get_event(3, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind || data != e.data) begin
            failures++;
            $display("FAIL dmg_sum: got=%0b kind=%0d dmg=%0d required kind=%0d dmg=%0d",
                     got, kind, data, e.kind, e.data);
        end
        @(negedge clk);
        checks++;
        if (atk.dmg_valid !== 1'b0) begin
            failures++;
            $display("FAIL dmg_width: dmg_valid=%b required 0", atk.dmg_valid);
        end
        atk.melee_hit = 1'b1;
        @(negedge clk);
        atk.melee_hit = 1'b0;
        get_event(4, got, kind, data);
        checks++;
        if (got) begin
            failures++;
            $display("FAIL dmg_second_melee: event kind=%0d data=%0d required none", kind, data);
        end
        atk.projectile_hit = 1'b1;
        exp_q.push_back('{KDmg, 1});
        @(negedge clk);
        atk.projectile_hit = 1'b0;
        get_event(3, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind || data != e.data) begin
            failures++;
            $display("FAIL dmg_ranged: got=%0b kind=%0d dmg=%0d required kind=%0d dmg=%0d",
                     got, kind, data, e.kind, e.data);
        end
        go_idle();
    endtask

    task automatic test_click_buffer();
        bit got; int kind; int data; int n; exp_t e;
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KSwing, 0});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind) begin
            failures++;
            $display("FAIL buf_start: got=%0b kind=%0d required kind=%0d", got, kind, e.kind);
        end
        run_frames(1'b1, n);
        atk.mouse_clicked = 1'b0;
        @(negedge clk);
        atk.mouse_clicked = 1'b1;
        @(negedge clk);
        run_frames(1'b0, n);
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL buf_cool_len: ticks=%0d required 20", n);
        end
`ifdef WEAPON_CLICK_BUFFER_EN
        exp_q.push_back('{KSwing, 0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (atk.swing_start !== 1'b1) begin
            failures++;
            $display("FAIL buf_replay: swing_start=%b one cycle after idle, required 1",
                     atk.swing_start);
        end
`else
        get_event(6, got, kind, data);
        checks++;
        if (got) begin
            failures++;
            $display("FAIL buf_ignored: event kind=%0d required none", kind);
        end
`endif
        go_idle();
    endtask

    task automatic test_reset_mid_cooldown();
        bit got; int kind; int data; int n; exp_t e;
        atk.mouse_clicked = 1'b1;
        @(negedge clk);
        run_frames(1'b1, n);
        checks++;
        if (atk.cooldown_active !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_cool_setup: cool=%b required 1", atk.cooldown_active);
        end
        #2;
        rst = 1'b0;
        atk.mouse_clicked = 1'b0;
        #1;
        checks++;
        if ({atk.swing_start, atk.swing_active, atk.fire_req, atk.cooldown_active,
             atk.dmg_valid} !== 5'b0) begin
            failures++;
            $display("FAIL rst_async: flags=%b required 00000", {atk.swing_start,
                     atk.swing_active, atk.fire_req, atk.cooldown_active, atk.dmg_valid});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        atk.mouse_clicked = 1'b1;
        exp_q.push_back('{KSwing, 0});
        @(negedge clk);
        get_event(4, got, kind, data);
        e = exp_q.pop_front();
        checks++;
        if (!got || kind != e.kind) begin
            failures++;
            $display("FAIL rst_then_idle: got=%0b kind=%0d required kind=%0d", got, kind, e.kind);
        end
        go_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_melee();
        test_abort();
        test_archer();
        test_damage();
        test_click_buffer();
        test_reset_mid_cooldown();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weapon_attack_ctrl.md
# weapon_attack_ctrl

Attack sequencer between the mouse input and the weapon datapath. It turns mouse clicks into rate-limited melee swings or projectile launches according to `char_class`, and allocates a free projectile slot for each launch. It also converts `melee_hit`/`projectile_hit` events into damage pulses for the boss logic. It sits beside the weapon top level, in the `clk` domain, driven once per frame by `frame_tick`.

## Interface
Parameters:
- `PROJECTILE_COUNT`, default 4: number of projectile slots.
- `SWING_FRAMES`, default 10: swing duration in frame_ticks, ≥1.
- `MELEE_COOLDOWN`, default 20: frames between swing end and the next attack, ≥1.
- `RANGED_COOLDOWN`, default 12: frames between a launch and the next attack, ≥1.

Ports (one clock `clk`; reset `rst` is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `game_active` in 2: attacks are enabled only when it equals `GAME_PLAYING` (2'd1).
- `char_class` in 2: `CLASS_MELEE` (2'd1) or `CLASS_ARCHER` (2'd2); any other value disables attacks.
- `mouse_clicked` in 1: level input, button held.
- `slot_busy` in PROJECTILE_COUNT: per-slot "projectile in flight" flags from the projectile animator.
- `melee_hit`, `projectile_hit` in 1: hit events from the weapon datapath.
- `swing_start` out 1: one-cycle pulse when a swing begins.
- `swing_active` out 1: high for the whole swing.
- `fire_req` out 1: one-cycle launch request.
- `fire_slot` out $clog2(PROJECTILE_COUNT): slot index, valid with `fire_req`.
- `cooldown_active` out 1: high in COOLDOWN.
- `dmg_valid` out 1, `dmg` out 8: damage pulse.

## Operation
- Click edge: `mouse_clicked` & ~`mouse_q`, where `mouse_q` is the registered previous sample.
- "Enabled" means `game_active`==GAME_PLAYING and `char_class` is MELEE or ARCHER.
- FSM states and transitions:
  - IDLE:
    - edge and MELEE → SWING.
    - edge and ARCHER with at least one free slot → FIRE.
    - edge and ARCHER with all slots busy → click dropped, stay in IDLE.
  - SWING: frame counter loaded with SWING_FRAMES, decremented on `frame_tick`. When `frame_tick` arrives with the counter at 1 → COOLDOWN, loaded with MELEE_COOLDOWN.
  - FIRE: lasts one cycle. `fire_req`=1, `fire_slot` = lowest index i with `slot_busy[i]`=0. Then → COOLDOWN, loaded with RANGED_COOLDOWN.
  - COOLDOWN: decremented on `frame_tick`. When `frame_tick` arrives with the counter at 1 → IDLE.
- Abort: if the block becomes not enabled, or `char_class` changes, in any state → IDLE next cycle. The counter is cleared, any pending click is cleared, and no `fire_req` is issued.
- Damage:
  - A `melee_hit` during SWING adds `MELEE_DMG` (4), at most once per swing, tracked by a per-swing latch.
  - A `projectile_hit` adds `RANGED_DMG` (1) in any state while enabled.
  - Simultaneous hits are summed, and the sum saturates at 255.
- Reset values: all outputs 0, state IDLE, counter 0, `mouse_q`=0, pending click 0.

## Timing
- Every output is registered.
- Click sampled at edge N → `swing_start`/`fire_req` high in cycle N+1.
- `swing_active` rises at N+1 and falls in the cycle after the SWING_FRAMES-th `frame_tick`.
- A `frame_tick` in the same cycle as the entry into SWING or COOLDOWN is not counted.
- The earliest next attack edge is accepted in the cycle after COOLDOWN exits.
- A hit input at cycle N → `dmg_valid` at N+1 for exactly one cycle.
- A click held continuously produces only one attack; a new edge is required for the next.

## Configuration
- `WEAPON_CLICK_BUFFER_EN` defined: a one-deep pending-click flag is added.
  - It is set by a click edge in SWING, FIRE or COOLDOWN.
  - It is consumed as if it were an edge on the IDLE cycle, giving an attack one cycle after IDLE is entered.
  - A further edge while the flag is set is discarded.
  - An abort clears the flag.
- Undefined: edges outside IDLE are ignored.

## Structure
- Shared package `weapon_pkg` holds:
  - the `weapon_state_t` enum,
  - CLASS_MELEE, CLASS_ARCHER, GAME_PLAYING,
  - MELEE_DMG, RANGED_DMG.
- Sub-module `free_slot_finder`: combinational lowest-zero priority encoder over `slot_busy`, producing `found` and `index`.

## Test plan
- MELEE, single click, SWING_FRAMES=10 → one `swing_start`; `swing_active` held for 10 frame_ticks; `cooldown_active` for 20; new click accepted afterwards.
- ARCHER, `slot_busy`=4'b0101 → `fire_req` with `fire_slot`=1. With `slot_busy`=4'b1111 → no `fire_req`, state stays IDLE.
- Two `melee_hit` pulses in one swing plus a simultaneous `projectile_hit` → first cycle `dmg`=5; the second melee hit gives no pulse.
- Click during COOLDOWN: with the macro, the attack follows 1 cycle after IDLE is entered; without it, no attack occurs.
- `game_active` drops mid-SWING → IDLE next cycle, all outputs 0. Asserting `rst` mid-COOLDOWN → all outputs 0 immediately, state IDLE.
